// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the accumulator CPU: field widths, opcode encoding,
// FSM state encoding and a small opcode classification helper.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int WORD = 16;
    localparam int ADDR = 10;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_NOT = 4'h8,
        OP_JMP = 4'h9,
        OP_JZ  = 4'hA,
        OP_JN  = 4'hB,
        OP_SHL = 4'hC,
        OP_SHR = 4'hD,
        OP_LDI = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_WSETUP,
        S_WRITE,
        S_HALT
    } state_t;

    // Ops whose EXEC cycle consumes a memory operand (the only ones that honour I).
    function automatic logic is_mem_op(input opcode_t op);
        return op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// -----------------------------------------------------------------------------
// cpu_alu
// Combinational accumulator datapath.
//   op     : current opcode (from IR)
//   acc    : accumulator value
//   m      : memory operand (data_in during EXEC)
//   imm    : operand address field A, used as the LDI immediate
//   c_in   : current carry flag
//   result : next accumulator value (acc when the op leaves ACC alone)
//   c_out  : next carry flag (c_in unless ADD/SUB/SHL/SHR)
// -----------------------------------------------------------------------------
module cpu_alu
    import cpu_pkg::*;
(
    input  opcode_t          op,
    input  logic [WORD-1:0]  acc,
    input  logic [WORD-1:0]  m,
    input  logic [ADDR-1:0]  imm,
    input  logic             c_in,
    output logic [WORD-1:0]  result,
    output logic             c_out
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        result = acc;
        c_out  = c_in;
        case (op)
            OP_LDA: result = m;
            // 17-bit arithmetic: bit 16 is carry-out for ADD and borrow for SUB.
            OP_ADD: {c_out, result} = {1'b0, acc} + {1'b0, m};
            OP_SUB: {c_out, result} = {1'b0, acc} - {1'b0, m};
            OP_AND: result = acc & m;
            OP_OR:  result = acc | m;
            OP_XOR: result = acc ^ m;
            OP_NOT: result = ~acc;
            OP_SHL: begin
                result = {acc[WORD-2:0], 1'b0};
                c_out  = acc[WORD-1];
            end
            OP_SHR: begin
                result = {1'b0, acc[WORD-1:1]};
                c_out  = acc[0];
            end
            OP_LDI: result = {{(WORD-ADDR){1'b0}}, imm};
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// -----------------------------------------------------------------------------
// cpu
// Multi-cycle 16-bit accumulator CPU with a 10-bit address space.
//   clk       : system clock, rising edge
//   rst_pc    : async active-high; clears FSM, PC, IR, EA and the write strobe
//   rst_acc   : async active-high; clears ACC and carry
//   data_in   : memory read data (mem[addr], or mem[mem[addr]] if addr_mode)
//   data_out  : write data, always ACC
//   addr      : memory address
//   wr        : write strobe, registered
//   addr_mode : 1 requests an indirect read through mem[addr]
// Outputs depend only on registered state, never on data_in.
// -----------------------------------------------------------------------------
module cpu
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_pc,
    input  logic             rst_acc,
    input  logic [WORD-1:0]  data_in,
    output logic [WORD-1:0]  data_out,
    output logic [ADDR-1:0]  addr,
    output logic             wr,
    output logic             addr_mode
);

    state_t          state;
    logic [ADDR-1:0] pc;
    logic [ADDR-1:0] ea;
    logic [WORD-1:0] ir;
    logic [WORD-1:0] acc;
    logic            c;

    opcode_t         op;
    logic            ind;
    logic [ADDR-1:0] a;
    logic            z;
    logic            n;
    logic            ir_unused;

    logic [WORD-1:0] alu_result;
    logic            alu_c;

    assign op        = opcode_t'(ir[15:12]);
    assign ind       = ir[10];
    assign a         = ir[ADDR-1:0];
    assign ir_unused = ir[11];          // reserved instruction bit, ignored
    assign z         = (acc == '0);
    assign n         = acc[WORD-1];
    assign data_out  = acc;

    cpu_alu u_alu (
        .op     (op),
        .acc    (acc),
        .m      (data_in),
        .imm    (a),
        .c_in   (c),
        .result (alu_result),
        .c_out  (alu_c)
    );

    // Address decode from registered state only.
    always_comb begin
        addr      = pc;
        addr_mode = 1'b0;
        case (state)
            S_FETCH:           addr = pc;
            S_EXEC: begin
                addr      = a;
                addr_mode = is_mem_op(op) & ind;
            end
            S_WSETUP, S_WRITE: addr = ea;
            S_HALT:            addr = pc;
            default:           addr = pc;
        endcase
    end

    // Control FSM. wr is a flop so the strobe is glitch-free and rises only
    // after addr has been stable for the whole WSETUP cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst_pc) begin
        if (rst_pc) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            ea    <= '0;
            wr    <= 1'b0;
        end else begin
            wr <= 1'b0;
            case (state)
                S_FETCH: begin
                    ir    <= data_in;
                    pc    <= pc + 10'd1;   // wraps 1023 -> 0
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (op)
                        OP_JMP: pc <= a;
                        OP_JZ:  if (z) pc <= a;
                        OP_JN:  if (n) pc <= a;
                        OP_STA: begin
                            // Indirect STA read the pointer with addr_mode=0.
                            ea    <= ind ? data_in[ADDR-1:0] : a;
                            state <= S_WSETUP;
                        end
                        OP_HLT: state <= S_HALT;
                        default: ;
                    endcase
                end
                S_WSETUP: begin
                    wr    <= 1'b1;
                    state <= S_WRITE;
                end
                S_WRITE:  state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Accumulator and carry; the ALU passes both through for ops that keep them.
    always_ff @(posedge clk or posedge rst_acc) begin
        if (rst_acc) begin
            acc <= '0;
            c   <= 1'b0;
        end else if (state == S_EXEC) begin
            acc <= alu_result;
            c   <= alu_c;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// -----------------------------------------------------------------------------
// tb_cpu
// Directed bench for cpu: behavioural memory with indirect read support,
// write monitor feeding an observed-write queue, expected writes queued as
// each program is loaded.
// -----------------------------------------------------------------------------
module tb_cpu;

    logic        clk;
    logic        rst_pc;
    logic        rst_acc;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [9:0]  addr;
    logic        wr;
    logic        addr_mode;

    logic [15:0] mem [1024];
    logic        tb_we;
    logic        tb_clr;
    logic [9:0]  tb_waddr;
    logic [15:0] tb_wdata;
    logic [15:0] ptr;

    logic [25:0] exp_q[$];
    logic [25:0] obs_q[$];

    int checks   = 0;
    int failures = 0;

    cpu dut (
        .clk       (clk),
        .rst_pc    (rst_pc),
        .rst_acc   (rst_acc),
        .data_in   (data_in),
        .data_out  (data_out),
        .addr      (addr),
        .wr        (wr),
        .addr_mode (addr_mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign ptr     = mem[addr];
    assign data_in = addr_mode ? mem[ptr[9:0]] : ptr;

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
        end else if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end
        if (wr) begin
            mem[addr] <= data_out;
            obs_q.push_back({addr, data_out});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poke(input logic [9:0] a, input logic [15:0] d);
        tb_we    = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    task automatic reset_all();
        rst_pc  = 1'b1;
        rst_acc = 1'b1;
        tb_clr  = 1'b1;
        @(negedge clk);
        tb_clr  = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic [25:0] o;
        logic [25:0] e;
        check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_write"}, {6'h0, o}, {6'h0, e});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_instr(input string tag, input logic [15:0] e_acc,
                             input logic e_c, input logic [9:0] e_addr);
        step(2);
        check({tag, "_acc"}, data_out, e_acc);
        check({tag, "_c"}, dut.c, e_c);
        check({tag, "_next_addr"}, addr, e_addr);
    endtask

    initial begin
        int bad;
        rst_pc   = 1'b1;
        rst_acc  = 1'b1;
        tb_we    = 1'b0;
        tb_clr   = 1'b0;
        tb_waddr = '0;
        tb_wdata = '0;
        @(negedge clk);

        // Reset state
        check("rst_addr", addr, 10'h000);
        check("rst_wr", wr, 1'b0);
        check("rst_addr_mode", addr_mode, 1'b0);
        check("rst_data_out", data_out, 16'h0000);

        // LDA / ADD / STA sequence, 8 cycles, single write of 000C to 0x193
        reset_all();
        poke(10'd0, 16'h1191);
        poke(10'd1, 16'h3192);
        poke(10'd2, 16'h2193);
        poke(10'd401, 16'h0005);
        poke(10'd402, 16'h0007);
        exp_q.push_back({10'h193, 16'h000C});
        rst_pc  = 1'b0;
        rst_acc = 1'b0;
        check("sum_first_fetch", addr, 10'h000);
        step(4);
        check("sum_acc", data_out, 16'h000C);
        step(2);
        check("sum_wsetup_addr", addr, 10'h193);
        check("sum_wsetup_wr", wr, 1'b0);
        step(1);
        check("sum_write_wr", wr, 1'b1);
        check("sum_write_addr", addr, 10'h193);
        step(1);
        check("sum_mem403", mem[403], 16'h000C);
        check("sum_wr_low", wr, 1'b0);
        drain("sum");

        // LDA indirect
        reset_all();
        poke(10'd0, 16'h1594);
        poke(10'd404, 16'h0191);
        poke(10'd401, 16'hABCD);
        rst_pc  = 1'b0;
        rst_acc = 1'b0;
        step(1);
        check("ind_exec_addr", addr, 10'h194);
        check("ind_exec_mode", addr_mode, 1'b1);
        step(1);
        check("ind_acc", data_out, 16'hABCD);
        check("ind_fetch_mode", addr_mode, 1'b0);

        // ALU, flags and branches
        reset_all();
        poke(10'h000, 16'h1100);
        poke(10'h001, 16'h3101);
        poke(10'h002, 16'hA020);
        poke(10'h020, 16'h4101);
        poke(10'h021, 16'hB030);
        poke(10'h030, 16'hC000);
        poke(10'h031, 16'hE0F0);
        poke(10'h032, 16'hD000);
        poke(10'h033, 16'h7102);
        poke(10'h034, 16'h5103);
        poke(10'h035, 16'h6104);
        poke(10'h036, 16'h8000);
        poke(10'h037, 16'hA000);
        poke(10'h100, 16'hFFFF);
        poke(10'h101, 16'h0001);
        poke(10'h102, 16'h00FF);
        poke(10'h103, 16'h000F);
        poke(10'h104, 16'h0100);
        rst_pc  = 1'b0;
        rst_acc = 1'b0;
        run_instr("lda", 16'hFFFF, 1'b0, 10'h001);
        run_instr("add_wrap", 16'h0000, 1'b1, 10'h002);
        run_instr("jz_taken", 16'h0000, 1'b1, 10'h020);
        run_instr("sub_borrow", 16'hFFFF, 1'b1, 10'h021);
        run_instr("jn_taken", 16'hFFFF, 1'b1, 10'h030);
        run_instr("shl", 16'hFFFE, 1'b1, 10'h031);
        run_instr("ldi", 16'h00F0, 1'b1, 10'h032);
        run_instr("shr", 16'h0078, 1'b0, 10'h033);
        run_instr("xor", 16'h0087, 1'b0, 10'h034);
        run_instr("and", 16'h0007, 1'b0, 10'h035);
        run_instr("or", 16'h0107, 1'b0, 10'h036);
        run_instr("not", 16'hFEF8, 1'b0, 10'h037);
        run_instr("jz_not_taken", 16'hFEF8, 1'b0, 10'h038);
        drain("alu");

        // HLT at 0x005, hold for 20 cycles, rst_pc restarts at 0
        reset_all();
        poke(10'h005, 16'hF000);
        rst_pc  = 1'b0;
        rst_acc = 1'b0;
        step(12);
        check("halt_addr", addr, 10'h006);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (addr !== 10'h006 || wr !== 1'b0) bad++;
        end
        check("halt_hold_bad_cycles", bad, 0);
        #2 rst_pc = 1'b1;
        #1;
        check("halt_rst_addr", addr, 10'h000);
        @(negedge clk);
        rst_pc = 1'b0;
        step(2);
        check("halt_restart_addr", addr, 10'h001);
        drain("halt");

        // STA indirect
        reset_all();
        poke(10'h000, 16'h11FF);
        poke(10'h001, 16'h2595);
        poke(10'h1FF, 16'h1234);
        poke(10'h195, 16'h01A0);
        exp_q.push_back({10'h1A0, 16'h1234});
        rst_pc  = 1'b0;
        rst_acc = 1'b0;
        step(3);
        check("stai_exec_addr", addr, 10'h195);
        check("stai_exec_mode", addr_mode, 1'b0);
        step(1);
        check("stai_wsetup_addr", addr, 10'h1A0);
        check("stai_wsetup_wr", wr, 1'b0);
        step(1);
        check("stai_write_wr", wr, 1'b1);
        check("stai_write_data", data_out, 16'h1234);
        step(1);
        check("stai_mem416", mem[10'h1A0], 16'h1234);
        check("stai_mem405", mem[10'h195], 16'h01A0);
        drain("stai");

        // PC wrap 1023 -> 0, rst_acc mid-program keeps PC
        reset_all();
        poke(10'h000, 16'hE055);
        poke(10'h001, 16'h93FF);
        rst_pc  = 1'b0;
        rst_acc = 1'b0;
        step(2);
        check("wrap_ldi", data_out, 16'h0055);
        step(1);
        #2 rst_acc = 1'b1;
        #1;
        check("wrap_rst_acc", data_out, 16'h0000);
        rst_acc = 1'b0;
        step(1);
        check("wrap_jmp_addr", addr, 10'h3FF);
        check("wrap_acc_kept0", data_out, 16'h0000);
        step(2);
        check("wrap_addr", addr, 10'h000);
        drain("wrap");

        // rst_pc aborts a pending write; rst_acc before WRITE writes zero
        reset_all();
        poke(10'h000, 16'h11FF);
        poke(10'h001, 16'h21A5);
        poke(10'h1FF, 16'h1234);
        poke(10'h1A5, 16'hFFFF);
        rst_pc  = 1'b0;
        rst_acc = 1'b0;
        step(5);
        check("abort_wsetup_addr", addr, 10'h1A5);
        rst_pc = 1'b1;
        #1;
        check("abort_wr", wr, 1'b0);
        check("abort_addr", addr, 10'h000);
        step(3);
        check("abort_mem", mem[10'h1A5], 16'hFFFF);
        drain("abort");
        rst_pc = 1'b0;
        step(5);
        check("zero_wsetup_addr", addr, 10'h1A5);
        rst_acc = 1'b1;
        #1;
        check("zero_data_out", data_out, 16'h0000);
        rst_acc = 1'b0;
        exp_q.push_back({10'h1A5, 16'h0000});
        step(2);
        check("zero_mem", mem[10'h1A5], 16'h0000);
        drain("zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
